// File: rtl/bnn_uart_pkg.sv
// Shared types and helpers for the BNN UART receive path.
package bnn_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int unsigned MAX_DATA_BITS = 9;

  // Counter width that can hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Expected parity bit: zero-extended data keeps the XOR unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/bnn_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only alongside a pop.
module bnn_sync_fifo #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_BITS-1:0]         push_data,
  input  logic                         pop,
  output logic [DATA_BITS-1:0]         pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bnn_uart_rx.sv
// Internally timed UART receiver with optional parity, receive FIFO,
// CTS flow control and one-cycle error pulses.
module bnn_uart_rx
  import bnn_uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CTS_MARGIN   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx,
  input  logic                       parity_en,
  input  logic                       parity_odd,
  output logic                       cts,
  output logic [DATA_BITS-1:0]       rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       frame_err,
  output logic                       parity_err,
  output logic                       overrun_err
);

  localparam int unsigned BAUD_W = cnt_width(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = cnt_width(DATA_BITS);
  localparam int unsigned CNT_W  = $clog2(DEPTH+1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  rx_state_t            state, state_next;
  logic                 rx_s1, rx_s2, rx_prev;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_en_l, par_odd_l, par_bad;
  logic                 sample;
  logic                 push, pop, full, empty;
  logic                 ferr_next, perr_next, oerr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // START samples mid-bit; later states sample one full bit period after that.
  always_comb begin
    sample = 1'b0;
    if (state == START) sample = (baud_cnt == HALF_LAST);
    else if (state != IDLE) sample = (baud_cnt == FULL_LAST);
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    ferr_next  = 1'b0;
    perr_next  = 1'b0;
    oerr_next  = 1'b0;
    case (state)
      IDLE:   if (rx_prev & ~rx_s2) state_next = START;
      START:  if (sample) state_next = rx_s2 ? IDLE : DATA;
      DATA:   if (sample && bit_cnt == BIT_LAST) state_next = par_en_l ? PARITY : STOP;
      PARITY: if (sample) state_next = STOP;
      STOP: begin
        if (sample) begin
          state_next = IDLE;
          if (!rx_s2)            ferr_next = 1'b1;
          else if (par_bad)      perr_next = 1'b1;
          else if (full && !pop) oerr_next = 1'b1;
          else                   push      = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_en_l    <= 1'b0;
      par_odd_l   <= 1'b0;
      par_bad     <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= ferr_next;
      parity_err  <= perr_next;
      overrun_err <= oerr_next;

      if (state_next != state || sample) baud_cnt <= '0;
      else if (state != IDLE)            baud_cnt <= baud_cnt + BAUD_W'(1);

      if (state == IDLE) bit_cnt <= '0;
      else if (state == DATA && sample)
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);

      if (state == DATA && sample) shreg <= {rx_s2, shreg[DATA_BITS-1:1]};

      if (state == IDLE && state_next == START) begin
        par_en_l  <= parity_en;
        par_odd_l <= parity_odd;
        par_bad   <= 1'b0;
      end else if (state == PARITY && sample) begin
        par_bad <= (rx_s2 != parity_bit(MAX_DATA_BITS'(shreg), par_odd_l));
      end
    end
  end

  assign pop      = rx_valid & rx_ready;
  assign rx_valid = ~empty;
  assign cts      = (fifo_count < CNT_W'(DEPTH - CTS_MARGIN));

  bnn_sync_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .pop_data  (rx_data),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_bnn_uart_rx.sv
// Self-checking bench for bnn_uart_rx: frame-level reference model plus directed literal checks.
module tb_bnn_uart_rx;

  localparam int DB     = 8;
  localparam int CPB    = 16;
  localparam int DEPTH  = 4;
  localparam int MARGIN = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx = 1'b1;
  logic         parity_en = 1'b0;
  logic         parity_odd = 1'b0;
  logic         rx_ready = 1'b0;
  logic         cts;
  logic [DB-1:0] rx_data;
  logic         rx_valid;
  logic [2:0]   fifo_count;
  logic         frame_err, parity_err, overrun_err;

  bnn_uart_rx #(
    .DATA_BITS    (DB),
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH),
    .CTS_MARGIN   (MARGIN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .cts         (cts),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .fifo_count  (fifo_count),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame outcome events, each due on the clock edge that ends its stop sample.
  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
    bit          stop_bad;
    bit          par_bad;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] mq[$];
  bit         m_ferr, m_perr, m_oerr;
  int unsigned cyc = 0;
  int unsigned n_ferr = 0, n_perr = 0, n_oerr = 0;

  always @(posedge clk) begin
    bit pop, push, full;
    logic [7:0] d;
    cyc++;
    m_ferr = 0; m_perr = 0; m_oerr = 0;
    push = 0; d = '0;
    if (!rst_n) begin
      mq.delete();
      evq.delete();
    end else begin
      pop  = rx_ready && (mq.size() > 0);
      full = (mq.size() == DEPTH);
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        d = evq[0].data;
        if (evq[0].stop_bad)     m_ferr = 1;
        else if (evq[0].par_bad) m_perr = 1;
        else if (full && !pop)   m_oerr = 1;
        else                     push = 1;
        void'(evq.pop_front());
      end
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(d);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("rx_valid", rx_valid, mq.size() > 0);
      check("fifo_count", fifo_count, mq.size());
      check("cts", cts, (DEPTH - mq.size()) > MARGIN);
      if (mq.size() > 0) check("rx_data", rx_data, mq[0]);
      check("frame_err", frame_err, m_ferr);
      check("parity_err", parity_err, m_perr);
      check("overrun_err", overrun_err, m_oerr);
      n_ferr += frame_err;
      n_perr += parity_err;
      n_oerr += overrun_err;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after a clock edge; returns #1 after a clock edge.
  task automatic send_frame(input logic [7:0] d, input bit pen, input bit podd,
                            input bit pbit, input bit stop_val, input int gap);
    ev_t e;
    int  nb;
    nb = 1 + DB + (pen ? 1 : 0) + 1;
    e.cyc      = cyc + 3 + CPB/2 + CPB*(nb - 1);
    e.data     = d;
    e.stop_bad = !stop_val;
    e.par_bad  = pen && (pbit != ((^d) ^ podd));
    evq.push_back(e);
    parity_en  = pen;
    parity_odd = podd;
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      cycles(CPB);
    end
    if (pen) begin
      rx = pbit;
      cycles(CPB);
    end
    rx = stop_val;
    cycles(CPB);
    rx = 1'b1;
    if (gap > 0) cycles(gap);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    cycles(1);
    rx_ready = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_rx_valid", rx_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_cts", cts, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_errs", {frame_err, parity_err, overrun_err}, 0);
  endtask

  bit rand_done;
  int unsigned errs_before;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;
    cycles(3);

    // 8N1 0xA5, held, then popped
    send_frame(8'hA5, 0, 0, 0, 1, 2);
    check("t1_valid", rx_valid, 1);
    check("t1_data", rx_data, 8'hA5);
    check("t1_count", fifo_count, 1);
    check("t1_no_err", n_ferr + n_perr + n_oerr, 0);
    pop_one();
    check("t1_pop_count", fifo_count, 0);
    check("t1_pop_valid", rx_valid, 0);

    // Even parity on 0x3C: bit 1 is wrong, bit 0 is right
    send_frame(8'h3C, 1, 0, 1, 1, 2);
    check("t2_perr", n_perr, 1);
    check("t2_count", fifo_count, 0);
    send_frame(8'h3C, 1, 0, 0, 1, 2);
    check("t2_good_data", rx_data, 8'h3C);
    check("t2_good_count", fifo_count, 1);
    pop_one();

    // Bad stop bit, then line idles high before a clean frame
    send_frame(8'h55, 0, 0, 0, 0, 20);
    check("t3_ferr", n_ferr, 1);
    check("t3_count", fifo_count, 0);
    send_frame(8'h01, 0, 0, 0, 1, 2);
    check("t3_data", rx_data, 8'h01);
    check("t3_count2", fifo_count, 1);
    pop_one();

    // Short low glitch is a false start
    errs_before = n_ferr + n_perr + n_oerr;
    rx = 1'b0;
    cycles(6);
    rx = 1'b1;
    cycles(40);
    check("t4_count", fifo_count, 0);
    check("t4_errs", n_ferr + n_perr + n_oerr, errs_before);

    // Fill past capacity with back-to-back frames
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h10 + 8'(i), 0, 0, 0, 1, 0);
      if (i == 1) check("t5_cts_at2", cts, 1);
      if (i == 2) begin
        check("t5_count3", fifo_count, 3);
        check("t5_cts_at3", cts, 0);
      end
    end
    check("t5_oerr", n_oerr, 1);
    check("t5_count4", fifo_count, 4);
    for (int i = 0; i < 4; i++) begin
      check("t5_drain_data", rx_data, 8'h10 + i);
      pop_one();
      if (i == 1) begin
        check("t5_drain_count2", fifo_count, 2);
        check("t5_drain_cts", cts, 1);
      end
    end
    check("t5_empty", rx_valid, 0);

    // Reset during data bit 3 of a frame
    parity_en = 1'b0;
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(i & 1);
      cycles(CPB);
    end
    rx = 1'b0;
    cycles(CPB/2);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    check_reset_values();
    cycles(3);
    rst_n = 1'b1;
    cycles(5);
    send_frame(8'hC3, 0, 0, 0, 1, 2);
    check("t6_data", rx_data, 8'hC3);
    check("t6_count", fifo_count, 1);
    pop_one();

    // Randomised frames with random back-pressure
    rand_done = 0;
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          logic [7:0] d;
          bit pen, podd, pbit, stop_ok;
          int gap;
          d       = 8'($urandom);
          pen     = 1'($urandom_range(0, 1));
          podd    = 1'($urandom_range(0, 1));
          pbit    = (^d) ^ podd ^ ($urandom_range(0, 5) == 0);
          stop_ok = ($urandom_range(0, 7) != 0);
          gap     = stop_ok ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
          send_frame(d, pen, podd, pbit, stop_ok, gap);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          rx_ready = ($urandom_range(0, 3) == 0);
          cycles(1);
        end
      end
    join
    rx_ready = 1'b1;
    cycles(10);
    rx_ready = 1'b0;
    check("final_empty", fifo_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bnn_uart_rx.md
# bnn_uart_rx

Parametrised UART receive front-end for the BNN controller. It replaces the fixed 8N1 receive path driven by an external baud pin with an internally timed receiver. The receiver adds an optional parity check, a receive FIFO, programmable CTS flow control and error reporting. It sits between the chip's serial input pin and the BNN controller's byte stream input.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame (5..9), LSB first.
- CLKS_PER_BIT, 16, clk cycles per bit period; must be >= 4.
- DEPTH, 4, receive FIFO entries; power of 2, >= 2.
- CTS_MARGIN, 1, cts deasserts when free FIFO slots <= CTS_MARGIN (1..DEPTH-1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- rx  in  1  serial line, idle high, asynchronous to clk.
- parity_en  in  1  1 = frame carries a parity bit after the data bits.
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- cts  out  1  1 = sender may transmit.
- rx_data  out  DATA_BITS  FIFO head (show-ahead).
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts the head when rx_valid is high.
- fifo_count  out  $clog2(DEPTH+1)  current occupancy.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- overrun_err  out  1  one-cycle pulse: good frame dropped because the FIFO was full.

## Operation
- rx passes through a 2-flop synchroniser that resets to 1. A third flop holds the previous synchronised value for edge detection.
- FSM states: IDLE, START, DATA, PARITY, STOP. Baud counter runs 0..CLKS_PER_BIT-1. Bit counter runs 0..DATA_BITS-1.
- IDLE -> START on a synchronised falling edge (prev=1, now=0). A line held low after reset or after an error does not start a frame.
- START: wait CLKS_PER_BIT/2 cycles, then sample. If the sample is 1, it is a false start: return to IDLE with no error. If 0, go to DATA.
- DATA: sample every CLKS_PER_BIT cycles and shift in LSB first. After DATA_BITS samples go to PARITY if parity_en, else STOP.
- parity_en and parity_odd are latched on the IDLE->START transition and stay constant for the whole frame.
- PARITY: one sample, compared against XOR(data) ^ parity_odd.
- STOP: one sample, then return to IDLE. The frame's outcome is decided at that sample, in this priority order:
  - Stop = 0: frame_err pulses and the data is dropped.
  - Parity bad: parity_err pulses and the data is dropped.
  - FIFO full and no pop this cycle: overrun_err pulses and the new data is dropped; FIFO contents are unchanged.
  - Otherwise: the data is pushed.
- FIFO: push and pop in the same cycle are both honoured, including when the FIFO is full (count stays unchanged). Pop only occurs when rx_valid & rx_ready. Pointers wrap modulo DEPTH.
- cts = (DEPTH - fifo_count) > CTS_MARGIN. It is combinational from the registered count.
- Reset values (also apply when reset is asserted mid-frame, which aborts the frame):
  - FSM IDLE, all counters 0, FIFO empty.
  - rx_valid=0, fifo_count=0, cts=1, all error pulses 0, rx_data=0.

## Timing
- Input latency: 2 cycles from an rx edge to the synchroniser output.
- Sample point: bit k (k=0 is the start bit) is sampled at cycle E + CLKS_PER_BIT/2 + k*CLKS_PER_BIT, where E is the edge-detect cycle.
- Push: the push register updates on the clock edge ending the stop-sample cycle. rx_valid and fifo_count reflect the push on the next cycle.
- Error pulses: high for exactly the one cycle after the stop sample.
- Pop: rx_data advances and fifo_count decrements on the cycle after the handshake. The consumer must not rely on rx_data while rx_valid=0.
- Frames may arrive back-to-back: a falling edge in the cycle after STOP completes starts the next frame.

## Structure
- Package bnn_uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - the parity-compute function;
  - localparam helpers for counter widths.
- Sub-module bnn_sync_fifo: parametrised DATA_BITS x DEPTH show-ahead FIFO with push, pop, count, full and empty.
- The top level contains the synchroniser, the FSM and the error and cts logic.

## Test plan
All scenarios use DATA_BITS=8, CLKS_PER_BIT=16, DEPTH=4, CTS_MARGIN=1.
- 8N1 frame 0xA5 with rx_ready=0 -> rx_valid=1, rx_data=0xA5, fifo_count=1, no error pulses. Then rx_ready=1 for one cycle -> fifo_count=0, rx_valid=0.
- parity_en=1, parity_odd=0, frame 0x3C sent with parity bit 1 -> parity_err pulses once, fifo_count stays 0. The same frame with parity bit 0 -> 0x3C pushed.
- Frame 0x55 with stop bit 0 -> frame_err pulse, nothing pushed. Then the line returns high and 0x01 is sent -> 0x01 received cleanly.
- rx pulled low for 6 cycles, then high -> no push, no errors, FSM back in IDLE.
- rx_ready=0, frames 0x10..0x14 sent -> cts falls when fifo_count reaches 3. 0x14 raises overrun_err. Draining yields 0x10, 0x11, 0x12, 0x13 in order, and cts returns to 1 when fifo_count drops to 2.
- rst_n pulsed low during data bit 3 of a frame -> all outputs at their reset values. The next complete frame 0xC3 is received correctly.
